// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared FSM encoding and sizing helpers for the UART feeder
package uart_tx_feeder_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// rtl/uart_tx_feeder_sync_fifo.sv - power-of-two synchronous FIFO with registered occupancy
module sync_fifo
   import uart_tx_feeder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        push_data_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        pop_data_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   // Acceptance is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign full_o     = (count_q == FULL_CNT);
   assign empty_o    = (count_q == '0);
   assign push_ok    = push_i && !full_o;
   assign pop_ok     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - frame queue and start/status sequencer in front of the UART transmitter
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int FRAME_BITS = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [FRAME_BITS-1:0]   wr_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    busy,
   output logic                    tx_start,
   output logic [FRAME_BITS-1:0]   tx_data,
   input  logic                    tx_status
);

   state_t                state_q;
   logic                  tx_start_q;
   logic [FRAME_BITS-1:0] tx_data_q;
   logic                  overflow_q;
   logic [FRAME_BITS-1:0] head;
   logic                  pop;

   assign pop = (state_q == IDLE) && !empty && !tx_status;

   sync_fifo #(
      .WIDTH (FRAME_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (wr_en),
      .push_data_i (wr_data),
      .pop_i       (pop),
      .pop_data_o  (head),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         if (wr_en && full) overflow_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  tx_data_q  <= head;
                  tx_start_q <= 1'b1;
                  state_q    <= START;
               end
            end
            START:     state_q <= WAIT_BUSY;
            WAIT_BUSY: if (tx_status)  state_q <= WAIT_DONE;
            WAIT_DONE: if (!tx_status) state_q <= GAP;
            // One dead cycle lets the transmitter settle back to idle before the next start.
            GAP:       state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder with a behavioural transmitter
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_status;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         m_count = 0;
   logic       acc_prev = 1'b0;
   int         start_cnt = 0;
   logic       tx_hold = 1'b0;
   int         ft = 4;

   uart_tx_feeder #(.FRAME_BITS(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .busy      (busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_status (tx_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got event expected none at %0t", name, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || !empty) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) fail("wait_idle_timeout");
   endtask

   // Transmitter model: latches one cycle after tx_start, then reports busy for ft cycles.
   initial begin
      logic       pend = 1'b0;
      int         tcnt = 0;
      logic [7:0] start_data = '0;
      tx_status = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 1'b0; tcnt = 0; tx_status = 1'b0;
         end else if (tx_hold) begin
            pend = 1'b0; tcnt = 0; tx_status = 1'b1;
         end else if (pend) begin
            pend = 1'b0;
            check("tx_data_held_at_latch", tx_data, start_data);
            tx_status = 1'b1;
            tcnt = ft;
         end else if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) tx_status = 1'b0;
         end else begin
            tx_status = 1'b0;
         end
         if (tx_start && !reset && !tx_hold) begin
            pend = 1'b1;
            start_data = tx_data;
         end
      end
   end

   // Scoreboard monitor: tracks occupancy and pops the expected frame on every start pulse.
   initial begin
      logic acc;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            m_count = 0;
            acc_prev = 1'b0;
         end else begin
            m_count = m_count + (acc_prev ? 1 : 0) - (tx_start ? 1 : 0);
            check("count", count, m_count);
            check("empty", empty, (m_count == 0));
            check("full", full, (m_count == DEPTH));
            if (tx_start) begin
               start_cnt++;
               if (exp_q.size() == 0) fail("unexpected_tx_start");
               else check("tx_data_order", tx_data, exp_q.pop_front());
            end
            acc = wr_en && (m_count != DEPTH);
            if (acc) exp_q.push_back(wr_data);
            acc_prev = acc;
         end
      end
   end

   initial begin
      int s0;
      reset = 1'b1; wr_en = 1'b0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      step();

      // Single frame latency
      wr_en = 1'b1; wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      check("single_count_n1", count, 1);
      check("single_start_n1", tx_start, 0);
      step();
      check("single_start_n2", tx_start, 1);
      check("single_data_n2", tx_data, 8'hA5);
      step();
      check("single_start_n3", tx_start, 0);
      check("single_busy_n3", busy, 1);
      wait_idle(200);
      check("single_data_hold", tx_data, 8'hA5);
      check("single_busy_end", busy, 0);

      // Burst of 16
      for (int i = 1; i <= 16; i++) begin
         check("burst_not_full", full, 0);
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      wait_idle(1000);
      check("burst_empty", empty, 1);
      check("burst_overflow", overflow, 0);
      check("burst_all_sent", exp_q.size(), 0);

      // Overflow with transmitter stuck busy
      tx_hold = 1'b1;
      step(); step();
      for (int i = 0; i < 18; i++) begin
         wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      check("ovf_count", count, 16);
      check("ovf_full", full, 1);
      check("ovf_flag", overflow, 1);
      repeat (3) step();
      check("ovf_sticky", overflow, 1);

      // Push while full in the same cycle as a pop
      tx_hold = 1'b0;
      wr_en = 1'b1; wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      check("pushpop_count", count, 15);
      check("pushpop_overflow", overflow, 1);
      check("pushpop_start", tx_start, 1);
      wait_idle(1000);
      check("ovf_drained", exp_q.size(), 0);

      // Wrap-around with random gaps
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(3, 14)) step();
         wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
         step();
         wr_en = 1'b0;
      end
      wait_idle(2000);
      check("wrap_drained", exp_q.size(), 0);
      check("wrap_overflow_sticky", overflow, 1);

      // Reset mid WAIT_DONE with 3 queued
      ft = 20;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'h51 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      begin
         int n = 0;
         while (!(busy && tx_status) && n < 50) begin step(); n++; end
         if (n >= 50) fail("wait_tx_busy_timeout");
      end
      step(); step();
      check("pre_rst_count", count, 3);
      reset = 1'b1;
      #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_tx_start", tx_start, 0);
      check("mid_rst_tx_data", tx_data, 0);
      check("mid_rst_overflow", overflow, 0);
      step(); step();
      reset = 1'b0;
      s0 = start_cnt;
      repeat (40) step();
      check("post_rst_no_start", start_cnt, s0);
      check("post_rst_count", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
